// File: rtl/fp_pkg.sv
// Shared types and helpers for the floating-point add/sub datapath.
package fp_pkg;

   // Operand class after unpacking; subnormals are reported as zero.
   typedef enum logic [1:0] {
      FP_ZERO = 2'd0,
      FP_NORM = 2'd1,
      FP_INF  = 2'd2,
      FP_NAN  = 2'd3
   } fp_class_e;

   // Significand width including the hidden bit.
   function automatic int man_w(input int data_w, input int exp_w);
      return data_w - exp_w;
   endfunction

   // Stored fraction width (no hidden bit).
   function automatic int frac_w(input int data_w, input int exp_w);
      return data_w - exp_w - 1;
   endfunction

   // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
   // Returned 64 bits wide; callers take the low data_w bits.
   function automatic logic [63:0] qnan(input int data_w, input int exp_w);
      logic [63:0] ones;
      ones = (64'd1 << (exp_w + 1)) - 64'd1;
      return ones << (data_w - exp_w - 2);
   endfunction

endpackage

// File: rtl/clz.sv
// Leading-zero counter; an all-zero input reports W.
module clz #(
   parameter int W  = 27,
   parameter int CW = $clog2(W + 1)
) (
   input  logic [W-1:0]  din,
   output logic [CW-1:0] cnt
);

   // Highest set bit wins because it is visited last.
   always_comb begin
      cnt = CW'(W);
      for (int i = 0; i < W; i++)
         if (din[i]) cnt = CW'(W - 1 - i);
   end

endmodule

// File: rtl/fp_classify.sv
// Unpacks one operand into sign/exponent/significand and classifies it.
module fp_classify import fp_pkg::*; #(
   parameter int DATA_W = 32,
   parameter int EXP_W  = 8
) (
   input  logic [DATA_W-1:0]       op,
   output fp_class_e               cls,
   output logic                    sign,
   output logic [EXP_W-1:0]        expo,
   output logic [DATA_W-EXP_W-1:0] man
);

   localparam int FRAC_W = frac_w(DATA_W, EXP_W);

   logic [FRAC_W-1:0] frac;

   assign sign = op[DATA_W-1];
   assign expo = op[DATA_W-2 -: EXP_W];
   assign frac = op[FRAC_W-1:0];

   // Class decode; zero exponent flushes subnormals to zero.
   always_comb begin
      cls = FP_NORM;
      if (expo == '0)      cls = FP_ZERO;
      else if (&expo)      cls = (frac != '0) ? FP_NAN : FP_INF;
   end

   assign man = (cls == FP_ZERO) ? '0 : {1'b1, frac};

endmodule

// File: rtl/fp_addsub.sv
// Five-stage pipelined floating-point adder/subtractor, RNE rounding.
module fp_addsub import fp_pkg::*; #(
   parameter int DATA_W = 32,
   parameter int EXP_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              sub,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic              done,
   output logic [DATA_W-1:0] res,
   output logic              overflow,
   output logic              underflow,
   output logic              exception
);

   localparam int MAN_W  = man_w(DATA_W, EXP_W);
   localparam int FRAC_W = frac_w(DATA_W, EXP_W);
   localparam int XW     = MAN_W + 3;          // significand + guard/round/sticky
   localparam int LZW    = $clog2(XW + 1);
   localparam int SPW    = DATA_W + 2;         // {hit, exc, value} of special path
   localparam logic [63:0]        QNAN64   = qnan(DATA_W, EXP_W);
   localparam logic [DATA_W-1:0]  QNAN     = QNAN64[DATA_W-1:0];
   localparam logic [EXP_W-1:0]   EXP_ONES = '1;
   localparam logic signed [EXP_W+1:0] E_ONE  = 1;
   localparam logic signed [EXP_W+1:0] E_ZERO = 0;
   localparam logic signed [EXP_W+1:0] E_MAX  = (1 << EXP_W) - 1;

   // token chain: vld_pipe[0]=d1 .. vld_pipe[3]=d4, vld_pipe[4]=done
   logic [4:0] vld_pipe;

   // ---------------- stage 1: unpack / classify / swap ----------------
   logic [DATA_W-1:0] op_b_eff;
   fp_class_e         ca, cb;
   logic              sa, sb;
   logic [EXP_W-1:0]  ea, eb;
   logic [MAN_W-1:0]  ma, mb;
   logic              a_big;
   logic [SPW-1:0]    sp1;

   assign op_b_eff = {op_b[DATA_W-1] ^ sub, op_b[DATA_W-2:0]};

   fp_classify #(.DATA_W(DATA_W), .EXP_W(EXP_W)) u_cls_a (
      .op(op_a), .cls(ca), .sign(sa), .expo(ea), .man(ma));
   fp_classify #(.DATA_W(DATA_W), .EXP_W(EXP_W)) u_cls_b (
      .op(op_b_eff), .cls(cb), .sign(sb), .expo(eb), .man(mb));

   // magnitude compare on {exp, frac} so equal exponents order correctly
   assign a_big = op_a[DATA_W-2:0] >= op_b[DATA_W-2:0];

   // Special-value result, highest precedence first.
   always_comb begin
      sp1 = {1'b1, 1'b0, {DATA_W{1'b0}}};
      if (ca == FP_NAN || cb == FP_NAN || (ca == FP_INF && cb == FP_INF && sa != sb))
         sp1 = {1'b1, 1'b1, QNAN};
      else if (ca == FP_INF)
         sp1[DATA_W-1:0] = {sa, EXP_ONES, {FRAC_W{1'b0}}};
      else if (cb == FP_INF)
         sp1[DATA_W-1:0] = {sb, EXP_ONES, {FRAC_W{1'b0}}};
      else if (ca == FP_ZERO && cb == FP_ZERO)
         sp1[DATA_W-1:0] = {sa & sb, {(DATA_W-1){1'b0}}};
      else if (ca == FP_ZERO)
         sp1[DATA_W-1:0] = op_b_eff;
      else if (cb == FP_ZERO)
         sp1[DATA_W-1:0] = op_a;
      else
         sp1[SPW-1] = 1'b0;
   end

   logic [SPW-1:0]   s1_sp;
   logic             s1_sign, s1_eff_sub;
   logic [EXP_W-1:0] s1_exp_a, s1_exp_b;
   logic [MAN_W-1:0] s1_man_a, s1_man_b;

   // Stage 1 register: larger-magnitude operand lands in the A slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_sp <= '0; s1_sign <= 1'b0; s1_eff_sub <= 1'b0;
         s1_exp_a <= '0; s1_exp_b <= '0; s1_man_a <= '0; s1_man_b <= '0;
      end else begin
         s1_sp      <= sp1;
         s1_eff_sub <= sa ^ sb;
         s1_sign    <= a_big ? sa : sb;
         s1_exp_a   <= a_big ? ea : eb;
         s1_exp_b   <= a_big ? eb : ea;
         s1_man_a   <= a_big ? ma : mb;
         s1_man_b   <= a_big ? mb : ma;
      end
   end

   // ---------------- stage 2: align ----------------
   logic [EXP_W-1:0] d2;
   logic [XW-1:0]    full_b, sh_b, lost_b, al_b;

   assign d2     = s1_exp_a - s1_exp_b;
   assign full_b = {s1_man_b, 3'b000};

   // Right shift with sticky collection, saturating at XW.
   always_comb begin
      sh_b   = full_b >> d2;
      lost_b = full_b & ~({XW{1'b1}} << d2);
      al_b   = {sh_b[XW-1:1], sh_b[0] | (|lost_b)};
      if (d2 >= EXP_W'(XW))
         al_b = {{(XW-1){1'b0}}, |s1_man_b};
   end

   logic [SPW-1:0]   s2_sp;
   logic             s2_sign, s2_eff_sub;
   logic [EXP_W-1:0] s2_exp;
   logic [MAN_W-1:0] s2_ma;
   logic [XW-1:0]    s2_mb;

   // Stage 2 register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_sp <= '0; s2_sign <= 1'b0; s2_eff_sub <= 1'b0;
         s2_exp <= '0; s2_ma <= '0; s2_mb <= '0;
      end else begin
         s2_sp <= s1_sp; s2_sign <= s1_sign; s2_eff_sub <= s1_eff_sub;
         s2_exp <= s1_exp_a; s2_ma <= s1_man_a; s2_mb <= al_b;
      end
   end

   // ---------------- stage 3: add / subtract ----------------
   logic [XW:0] ext_a, ext_b, sum3;

   assign ext_a = {1'b0, s2_ma, 3'b000};
   assign ext_b = {1'b0, s2_mb};
   // B never exceeds A, so the difference is never negative
   assign sum3  = s2_eff_sub ? (ext_a - ext_b) : (ext_a + ext_b);

   logic [SPW-1:0]   s3_sp;
   logic             s3_sign;
   logic [EXP_W-1:0] s3_exp;
   logic [XW:0]      s3_sum;

   // Stage 3 register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s3_sp <= '0; s3_sign <= 1'b0; s3_exp <= '0; s3_sum <= '0;
      end else begin
         s3_sp <= s2_sp; s3_sign <= s2_sign; s3_exp <= s2_exp; s3_sum <= sum3;
      end
   end

   // ---------------- stage 4: normalize ----------------
   logic [LZW-1:0]          lzc;
   logic [XW-1:0]           nm4;
   logic signed [EXP_W+1:0] e_wide, e4;

   clz #(.W(XW), .CW(LZW)) u_clz (.din(s3_sum[XW-1:0]), .cnt(lzc));

   assign e_wide = $signed({2'b00, s3_exp});

   // Carry shifts right (dropped bit into sticky); otherwise shift out leading zeros.
   always_comb begin
      nm4 = s3_sum[XW-1:0] << lzc;
      e4  = e_wide - $signed({{(EXP_W+2-LZW){1'b0}}, lzc});
      if (s3_sum[XW]) begin
         nm4 = {s3_sum[XW:2], s3_sum[1] | s3_sum[0]};
         e4  = e_wide + E_ONE;
      end
   end

   logic [SPW-1:0]          s4_sp;
   logic                    s4_sign, s4_zero;
   logic signed [EXP_W+1:0] s4_exp;
   logic [XW-1:0]           s4_nm;

   // Stage 4 register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s4_sp <= '0; s4_sign <= 1'b0; s4_zero <= 1'b0; s4_exp <= '0; s4_nm <= '0;
      end else begin
         s4_sp <= s3_sp; s4_sign <= s3_sign; s4_zero <= (s3_sum == '0);
         s4_exp <= e4; s4_nm <= nm4;
      end
   end

   // ---------------- stage 5: round / pack / flags ----------------
   logic                    inc;
   logic [MAN_W:0]          rnd;
   logic signed [EXP_W+1:0] e5;
   logic [FRAC_W-1:0]       frac5;
   logic [DATA_W-1:0]       res5;
   logic                    ov5, un5, ex5;
   logic                    unused_hidden;

   assign inc   = s4_nm[2] & (s4_nm[1] | s4_nm[0] | s4_nm[3]);
   assign rnd   = {1'b0, s4_nm[XW-1:3]} + {{MAN_W{1'b0}}, inc};
   assign e5    = s4_exp + (rnd[MAN_W] ? E_ONE : E_ZERO);
   // rounding carry-out leaves 1.000..0, so the fraction is zero
   assign frac5 = rnd[MAN_W] ? '0 : rnd[FRAC_W-1:0];
   assign unused_hidden = rnd[MAN_W-1];

   // Result select: special path, cancellation, overflow, underflow, normal.
   always_comb begin
      res5 = {s4_sign, e5[EXP_W-1:0], frac5};
      ov5  = 1'b0;
      un5  = 1'b0;
      ex5  = 1'b0;
      if (s4_sp[SPW-1]) begin
         res5 = s4_sp[DATA_W-1:0];
         ex5  = s4_sp[SPW-2];
      end else if (s4_zero) begin
         res5 = '0;
      end else if (e5 >= E_MAX) begin
         res5 = {s4_sign, EXP_ONES, {FRAC_W{1'b0}}};
         ov5  = 1'b1;
      end else if (e5 <= E_ZERO) begin
         res5 = {s4_sign, {(DATA_W-1){1'b0}}};
         un5  = 1'b1;
      end
   end

   // Token chain; reset drops every in-flight token.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) vld_pipe <= '0;
      else     vld_pipe <= {vld_pipe[3:0], start};
   end

   assign done = vld_pipe[4];

   // Output registers load only with a stage-4 token and hold otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res <= '0; overflow <= 1'b0; underflow <= 1'b0; exception <= 1'b0;
      end else if (vld_pipe[3]) begin
         res <= res5; overflow <= ov5; underflow <= un5; exception <= ex5;
      end
   end

endmodule

// File: tb/tb_fp_addsub.sv
// Scoreboard bench for fp_addsub: stimulus pushes expectations, monitor pops on done.
module tb_fp_addsub;

   logic        clk = 1'b0;
   logic        rst, start, sub;
   logic [31:0] op_a, op_b, res;
   logic        done, overflow, underflow, exception;

   always #5 clk = ~clk;

   fp_addsub #(.DATA_W(32), .EXP_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
      .done(done), .res(res), .overflow(overflow), .underflow(underflow),
      .exception(exception));

   typedef struct packed {
      logic [31:0] res;
      logic        ov, un, ex;
      logic [31:0] cyc;
   } exp_t;

   exp_t   sb_q[$];
   exp_t   hold_exp = '0;
   exp_t   mon_e;
   int     tests = 0, fails = 0;
   int     cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: compare each done against the scoreboard head; between pulses outputs must hold.
   always @(negedge clk) begin
      if (!rst) begin
         if (done) begin
            if (sb_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_done: res %h with empty scoreboard (t=%0t)", res, $time);
            end else begin
               mon_e = sb_q.pop_front();
               chk("result", {29'd0, res, overflow, underflow, exception},
                   {29'd0, mon_e.res, mon_e.ov, mon_e.un, mon_e.ex});
               chk("latency", 64'(cyc), 64'(mon_e.cyc));
               hold_exp = mon_e;
            end
         end else begin
            chk("hold", {29'd0, res, overflow, underflow, exception},
                {29'd0, hold_exp.res, hold_exp.ov, hold_exp.un, hold_exp.ex});
         end
      end
   end

   // Drive one start for a cycle and record its expected response.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] r, input logic ov, input logic un, input logic ex);
      exp_t e;
      e.res = r; e.ov = ov; e.un = un; e.ex = ex;
      e.cyc = 32'(cyc + 5);
      sb_q.push_back(e);
      start = 1'b1; op_a = a; op_b = b; sub = s;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run1(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] r, input logic ov, input logic un, input logic ex);
      issue(a, b, s, r, ov, un, ex);
      repeat (6) @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && sb_q.size() > 0; i++) @(negedge clk);
      if (sb_q.size() > 0) begin
         tests++; fails++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
      repeat (3) @(negedge clk);
      chk("reset_state", {28'd0, done, res, overflow, underflow, exception}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // isolated directed vectors
      run1(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 0, 0, 0); // 1+2
      run1(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 0, 0, 0); // 1-1 cancel
      run1(32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 0, 1, 0); // underflow
      run1(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1, 0, 0); // overflow
      run1(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 0, 0, 1); // inf-inf
      run1(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 0, 0, 0); // tie -> even
      run1(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 0, 0, 0); // tie -> up
      run1(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 0, 0, 0); // above half
      run1(32'h3F800000, 32'h0D800000, 1'b0, 32'h3F800000, 0, 0, 0); // shift saturates

      // back-to-back, mixed add/sub
      issue(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 0, 0, 0); // 3-1
      issue(32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 0, 0, 0); // 1+(-1)
      issue(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 0, 0, 0); // inf+1
      issue(32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 0, 0, 0); // 1-inf
      issue(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 0, 0, 0); // -0+-0
      issue(32'h00000000, 32'h40490FDB, 1'b1, 32'hC0490FDB, 0, 0, 0); // 0-pi
      issue(32'hC0000000, 32'h40400000, 1'b0, 32'h3F800000, 0, 0, 0); // -2+3
      issue(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 0, 0, 1); // NaN in
      repeat (12) @(negedge clk);   // hold window after last done

      // reset with three tokens in flight
      issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 0, 0, 0);
      issue(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 0, 0, 0);
      issue(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 0, 0, 0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("async_reset", {28'd0, done, res, overflow, underflow, exception}, 64'd0);
      sb_q.delete();
      hold_exp = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);    // no done may appear for flushed tokens
      issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 0, 0, 0);
      drain();
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
